// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter on the core data bus.
// TXDATA pushes into a small FIFO; STATUS reports FIFO and line state.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 4,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        hit,
  output logic        tx,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd4;
  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;

  state_t state, state_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic [7:0]  shift, shift_d;
  logic [2:0]  bitcnt, bitcnt_d;
  logic [15:0] baud, baud_d;
  logic        tx_d;

  logic sel_tx, sel_st;
  logic empty, full, active;
  logic push, push_ok, pop, baud_end;
  logic [4:0] cnt_w;
  logic [2:0] cnt_sat;
  logic [7:0] head;
  logic       unused_bits;

  assign sel_tx = (DataAdr == BASE_ADDR);
  assign sel_st = (DataAdr == STAT_ADDR);
  assign hit    = sel_tx | sel_st;

  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign active = (state != IDLE);
  assign busy   = active | ~empty;

  assign head     = mem[rptr];
  assign push     = MemWrite & sel_tx;
  // a full FIFO still takes a byte when the FSM frees a slot this edge
  assign push_ok  = push & (~full | pop);
  assign baud_end = (baud == BAUD_MAX);

  assign cnt_w   = 5'(count);
  assign cnt_sat = (cnt_w > 5'd7) ? 3'd7 : cnt_w[2:0];

  assign ReadData = sel_st
    ? {25'b0, cnt_sat, overflow, empty, full, active}
    : 32'b0;

  assign unused_bits = ^WriteData[31:8];

  always_comb begin
    state_d  = state;
    tx_d     = tx;
    shift_d  = shift;
    bitcnt_d = bitcnt;
    baud_d   = baud;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          shift_d  = head;
          bitcnt_d = 3'd0;
          baud_d   = 16'd0;
          tx_d     = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = 16'd0;
          tx_d    = shift[0];
          state_d = DATA;
        end else begin
          baud_d = baud + 16'd1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = 16'd0;
          if (bitcnt == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bitcnt_d = bitcnt + 3'd1;
            shift_d  = {1'b0, shift[7:1]};
            tx_d     = shift[1];
          end
        end else begin
          baud_d = baud + 16'd1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = 16'd0;
          if (!empty) begin
            pop      = 1'b1;
            shift_d  = head;
            bitcnt_d = 3'd0;
            tx_d     = 1'b0;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shift    <= '0;
      bitcnt   <= '0;
      baud     <= '0;
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state  <= state_d;
      tx     <= tx_d;
      shift  <= shift_d;
      bitcnt <= bitcnt_d;
      baud   <= baud_d;
      if (pop)     rptr <= rptr + 1'b1;
      if (push_ok) wptr <= wptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !push_ok)
        overflow <= 1'b1;
      else if (MemWrite && sel_st && WriteData[0])
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push_ok) mem[wptr] <= WriteData[7:0];
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-level model compared every cycle,
// plus directed literal checks on status words and bit patterns.
module tb_mmio_uart_tx;

  localparam int C = 4;
  localparam int D = 4;
  localparam logic [31:0] TXA = 32'h0000_0100;
  localparam logic [31:0] STA = 32'h0000_0104;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic [31:0] ReadData;
  logic        hit;
  logic        tx;
  logic        busy;

  mmio_uart_tx dut (
    .clk(clk),
    .reset(reset),
    .MemWrite(MemWrite),
    .DataAdr(DataAdr),
    .WriteData(WriteData),
    .ReadData(ReadData),
    .hit(hit),
    .tx(tx),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Frame-level model: a byte queue plus the cycle offset in the frame.
  byte unsigned q[$];
  logic [7:0]   cur = 8'h0;
  bit           in_frame = 0;
  int           t = 0;
  bit           ovf = 0;
  bit           armed = 0;

  task automatic model_step();
    if (!reset) begin
      q.delete();
      in_frame = 0;
      t = 0;
      ovf = 0;
      armed = 1;
    end else begin
      if (in_frame) begin
        t++;
        if (t == 10 * C) in_frame = 0;
      end
      if (!in_frame && q.size() > 0) begin
        cur = q.pop_front();
        in_frame = 1;
        t = 0;
      end
      if (MemWrite && DataAdr == TXA) begin
        if (q.size() < D) q.push_back(WriteData[7:0]);
        else ovf = 1;
      end
      if (MemWrite && DataAdr == STA && WriteData[0]) ovf = 0;
    end
  endtask

  function automatic logic exp_tx();
    int k;
    if (!in_frame) return 1'b1;
    k = t / C;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return logic'((int'(cur) >> (k - 1)) & 1);
  endfunction

  function automatic logic [31:0] exp_rd();
    int n, sat, v;
    if (DataAdr != STA) return 32'h0;
    n = q.size();
    sat = (n > 7) ? 7 : n;
    v = sat * 16 + int'(ovf) * 8 + int'(n == 0) * 4
      + int'(n == D) * 2 + int'(in_frame);
    return 32'(v);
  endfunction

  always @(posedge clk) begin
    model_step();
    #1;
    if (armed) begin
      check("tx", 32'(tx), 32'(exp_tx()));
      check("busy", 32'(busy), 32'(in_frame || q.size() > 0));
      check("hit", 32'(hit),
            32'(DataAdr == TXA || DataAdr == STA));
      check("rdata", ReadData, exp_rd());
    end
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1;
    DataAdr = a;
    WriteData = d;
    @(negedge clk);
    MemWrite = 1'b0;
    DataAdr = 32'h0;
    WriteData = 32'h0;
  endtask

  logic seq [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                     1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    // reset held for two edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    DataAdr = STA;
    #1;
    check("rst_status", ReadData, 32'h0000_0004);
    check("rst_tx", 32'(tx), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    DataAdr = 32'h0;
    @(negedge clk);

    // single byte 0x19
    do_store(TXA, 32'h0000_0019);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #2;
      if (k % 4 == 2) check("bit", 32'(tx), 32'(seq[k / 4]));
      if (k == 20) check("busy_mid", 32'(busy), 32'h1);
    end
    @(posedge clk);
    #2;
    check("busy_after", 32'(busy), 32'h0);
    @(negedge clk);

    // back-to-back frames
    do_store(TXA, 32'h0000_0041);
    do_store(TXA, 32'h0000_0042);
    DataAdr = STA;
    #1;
    check("cnt_one", (ReadData >> 4) & 32'd7, 32'd1);
    DataAdr = 32'h0;
    repeat (85) @(negedge clk);
    check("b2b_done", 32'(busy), 32'h0);

    // overflow on the sixth consecutive push
    for (int i = 0; i < 6; i++) do_store(TXA, 32'h0000_0050 + 32'(i));
    DataAdr = STA;
    #1;
    check("ovf_status", ReadData, 32'h0000_004B);
    do_store(STA, 32'h0000_0001);
    DataAdr = STA;
    #1;
    check("ovf_clear", ReadData, 32'h0000_0043);
    DataAdr = 32'h0;
    repeat (230) @(negedge clk);
    check("ovf_drain", 32'(busy), 32'h0);

    // decode boundaries
    MemWrite = 1'b1;
    WriteData = 32'h0000_0077;
    DataAdr = 32'h0000_00FC;
    #1;
    check("hit_fc", 32'(hit), 32'h0);
    check("rd_fc", ReadData, 32'h0);
    @(negedge clk);
    DataAdr = 32'h0000_0108;
    #1;
    check("hit_108", 32'(hit), 32'h0);
    check("rd_108", ReadData, 32'h0);
    @(negedge clk);
    MemWrite = 1'b0;
    WriteData = 32'h0;
    DataAdr = STA;
    #1;
    check("hit_104", 32'(hit), 32'h1);
    check("dec_status", ReadData, 32'h0000_0004);
    repeat (3) @(negedge clk);
    check("dec_busy", 32'(busy), 32'h0);
    DataAdr = 32'h0;

    // reset in the middle of a frame with two bytes queued
    do_store(TXA, 32'h0000_0011);
    do_store(TXA, 32'h0000_0022);
    do_store(TXA, 32'h0000_0033);
    repeat (14) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    DataAdr = STA;
    #1;
    check("abort_tx", 32'(tx), 32'h1);
    check("abort_status", ReadData, 32'h0000_0004);
    check("abort_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    DataAdr = 32'h0;
    repeat (60) @(negedge clk);
    check("abort_quiet_tx", 32'(tx), 32'h1);
    check("abort_quiet_busy", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
